// File: rtl/icache_sa.sv
// icache_sa: set-associative I-cache, multi-word lines, refill FSM toward MC.
// Ports: IF req/addr -> inst/valid/stall (comb); MC word req/addr out, word in; flush.
module icache_sa #(
  parameter int ADDR_W     = 18,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              flush_in,
  input  logic              mem_mc_access_in,
  input  logic              mc_busy_mem_in,
  input  logic              mc_word_valid_in,
  input  logic [31:0]       mc_word_in,
  output logic              if_inst_valid_out,
  output logic [31:0]       if_inst_out,
  output logic              if_stall_out,
  output logic              mc_req_out,
  output logic [ADDR_W-1:0] mc_addr_out
);

  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int K_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;

  logic [31:0]      data_q  [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [WAY_W-1:0]  vic_q;
  logic [K_W-1:0]    k_q;
  logic              mc_req_q;
  logic [ADDR_W-1:0] mc_addr_q;

  logic [TAG_W-1:0] tag_in;
  logic [IDX_W-1:0] idx_in;
  logic [K_W-1:0]   word_in;
  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] base_tag;
  logic             unused_bits;

  assign tag_in   = if_addr_in[ADDR_W-1:IDX_W+OFF_W];
  assign idx_in   = if_addr_in[IDX_W+OFF_W-1:OFF_W];
  assign word_in  = K_W'(if_addr_in[ADDR_W-1:2]) & K_W'(LINE_WORDS - 1);
  assign base_idx = base_q[IDX_W+OFF_W-1:OFF_W];
  assign base_tag = base_q[ADDR_W-1:IDX_W+OFF_W];
  assign unused_bits = ^if_addr_in[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             found;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_in][w] && tag_q[idx_in][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Prefer an empty way; fall back to round-robin only when the set is full.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[idx_in][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) victim = rr_q[idx_in];
  end

  assign if_inst_valid_out = if_req_in && hit;
  assign if_inst_out  = (if_req_in && hit) ? data_q[idx_in][hit_way][word_in] : 32'h0;
  assign if_stall_out = if_req_in && !hit;
  assign mc_req_out   = mc_req_q;
  assign mc_addr_out  = mc_addr_q;

  logic mem_busy;
  logic last;
  logic fill_we;
  logic [WAY_W-1:0] rr_next;

  assign mem_busy = mem_mc_access_in || mc_busy_mem_in;
  assign last     = (k_q == K_W'(LINE_WORDS - 1));
  assign fill_we  = rdy_in && !flush_in && state_q == S_FILL
                 && mc_word_valid_in;
  assign rr_next  = (rr_q[base_idx] == WAY_W'(WAYS - 1))
                  ? '0 : rr_q[base_idx] + WAY_W'(1);

  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      data_q[base_idx][vic_q][k_q] <= mc_word_in;
      if (last) tag_q[base_idx][vic_q] <= base_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      base_q    <= '0;
      vic_q     <= '0;
      k_q       <= '0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
        state_q  <= S_IDLE;
        mc_req_q <= 1'b0;
        k_q      <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (if_req_in && !hit) begin
              base_q <= {if_addr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
              vic_q  <= victim;
              k_q    <= '0;
              // a half-filled line must never hit
              valid_q[idx_in][victim] <= 1'b0;
              if (mem_busy) begin
                state_q <= S_WAIT;
              end else begin
                state_q   <= S_FILL;
                mc_req_q  <= 1'b1;
                mc_addr_q <= {if_addr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
              end
            end
          end
          S_WAIT: begin
            if (!mem_busy) begin
              state_q   <= S_FILL;
              mc_req_q  <= 1'b1;
              mc_addr_q <= base_q + (ADDR_W'(k_q) << 2);
            end
          end
          S_FILL: begin
            if (mc_word_valid_in) begin
              if (last) begin
                valid_q[base_idx][vic_q] <= 1'b1;
                rr_q[base_idx] <= rr_next;
                mc_req_q <= 1'b0;
                k_q      <= '0;
                state_q  <= S_IDLE;
              end else begin
                k_q <= k_q + K_W'(1);
                if (mem_mc_access_in) begin
                  state_q  <= S_WAIT;
                  mc_req_q <= 1'b0;
                end else begin
                  mc_addr_q <= base_q + (ADDR_W'(k_q + K_W'(1)) << 2);
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed bench for icache_sa with an MC responder model.
// Expected MC word addresses are queued at stimulus time and checked on accept.
module tb_icache_sa;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [17:0] if_addr_in;
  logic        flush_in;
  logic        mem_mc_access_in;
  logic        mc_busy_mem_in;
  logic        mc_word_valid_in;
  logic [31:0] mc_word_in;
  logic        if_inst_valid_out;
  logic [31:0] if_inst_out;
  logic        if_stall_out;
  logic        mc_req_out;
  logic [17:0] mc_addr_out;

  int passes = 0;
  int total  = 0;
  logic [17:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  icache_sa dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .flush_in(flush_in), .mem_mc_access_in(mem_mc_access_in),
    .mc_busy_mem_in(mc_busy_mem_in),
    .mc_word_valid_in(mc_word_valid_in), .mc_word_in(mc_word_in),
    .if_inst_valid_out(if_inst_valid_out), .if_inst_out(if_inst_out),
    .if_stall_out(if_stall_out), .mc_req_out(mc_req_out),
    .mc_addr_out(mc_addr_out)
  );

  function automatic logic [31:0] mem(input logic [17:0] a);
    return {14'h2B3C, a};
  endfunction

  // MC answers in the same cycle the request is visible
  assign mc_word_valid_in = mc_req_out;
  assign mc_word_in       = mem(mc_addr_out);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_line(input logic [17:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 18'(4 * i));
  endtask

  // words accepted by the DUT on the coming edge
  always @(negedge clk_in) begin
    #3;
    if (rst_n_in && rdy_in && !flush_in && mc_req_out && mc_word_valid_in) begin
      if (exp_q.size() == 0) check("mc_unexpected", 32'(mc_addr_out), 32'h3FFFF);
      else check("mc_addr", 32'(mc_addr_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_hit(input logic [17:0] a, input int exp_n);
    int n;
    n = 0;
    while (!if_inst_valid_out && n < 60) begin
      @(negedge clk_in); #1; n++;
    end
    check("hit_valid", 32'(if_inst_valid_out), 32'd1);
    if (exp_n >= 0) check("stall_cycles", 32'(n), 32'(exp_n));
    check("hit_inst", if_inst_out, mem(a));
    check("hit_stall", 32'(if_stall_out), 32'd0);
  endtask

  task automatic fetch(input logic [17:0] a, input int exp_n);
    @(negedge clk_in);
    if_req_in = 1'b1; if_addr_in = a; #1;
    wait_hit(a, exp_n);
  endtask

  task automatic probe(input logic [17:0] a, input logic exp_hit);
    @(negedge clk_in);
    if_req_in = 1'b1; if_addr_in = a; #1;
    check("probe_valid", 32'(if_inst_valid_out), 32'(exp_hit));
    check("probe_stall", 32'(if_stall_out), 32'(!exp_hit));
    #1 if_req_in = 1'b0;
  endtask

  task automatic wait_addr(input logic [17:0] a);
    int n;
    n = 0;
    while (!(mc_req_out && mc_addr_out == a) && n < 30) begin
      @(negedge clk_in); #1; n++;
    end
    check("wait_addr", {13'd0, mc_req_out, mc_addr_out}, {13'd0, 1'b1, a});
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; if_req_in = 1'b0; if_addr_in = '0;
    flush_in = 1'b0; mem_mc_access_in = 1'b0; mc_busy_mem_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    check("rst_req", 32'(mc_req_out), 32'd0);
    check("rst_addr", 32'(mc_addr_out), 32'd0);
    check("rst_valid", 32'(if_inst_valid_out), 32'd0);
    check("rst_stall", 32'(if_stall_out), 32'd0);
    check("rst_inst", if_inst_out, 32'd0);
    if_req_in = 1'b1; if_addr_in = 18'h00100; #1;
    check("rst_miss", 32'(if_stall_out), 32'd1);
    if_req_in = 1'b0;
    @(negedge clk_in) rst_n_in = 1'b1;

    // cold miss, 5-cycle stall, then hit on word 2
    push_line(18'h00100);
    fetch(18'h00100, 5);
    fetch(18'h00108, 0);

    // three lines in set 0: third evicts way 0
    push_line(18'h00000); fetch(18'h00000, 5);
    push_line(18'h10000); fetch(18'h10000, 5);
    push_line(18'h20000); fetch(18'h20000, 5);
    probe(18'h1000C, 1'b1);
    probe(18'h00004, 1'b0);
    probe(18'h20008, 1'b1);

    // MEM contention at miss and mid-fill
    @(negedge clk_in);
    mem_mc_access_in = 1'b1; mc_busy_mem_in = 1'b1;
    push_line(18'h00200);
    if_req_in = 1'b1; if_addr_in = 18'h00200;
    repeat (3) begin
      @(negedge clk_in); #1;
      check("wait_noreq", 32'(mc_req_out), 32'd0);
    end
    mem_mc_access_in = 1'b0; mc_busy_mem_in = 1'b0;
    wait_addr(18'h00204);
    mem_mc_access_in = 1'b1;
    repeat (2) begin
      @(negedge clk_in); #1;
      check("pause_noreq", 32'(mc_req_out), 32'd0);
    end
    mem_mc_access_in = 1'b0;
    wait_addr(18'h00208);
    wait_hit(18'h00200, -1);
    probe(18'h0020C, 1'b1);

    // flush mid-fill after two words
    @(negedge clk_in);
    push_line(18'h00300);
    if_req_in = 1'b1; if_addr_in = 18'h00300;
    wait_addr(18'h00308);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0; #1;
    check("flush_req", 32'(mc_req_out), 32'd0);
    exp_q.delete();
    push_line(18'h00300);
    if_addr_in = 18'h00100; #1;
    check("flush_miss", 32'(if_inst_valid_out), 32'd0);
    if_addr_in = 18'h00300;
    wait_addr(18'h00300);
    wait_hit(18'h00300, -1);
    probe(18'h10000, 1'b0);

    // rdy low for 3 cycles mid-fill
    @(negedge clk_in);
    push_line(18'h00400);
    if_req_in = 1'b1; if_addr_in = 18'h00400;
    wait_addr(18'h00404);
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in); #1;
      check("frz_addr", {13'd0, mc_req_out, mc_addr_out}, {13'd0, 1'b1, 18'h00404});
    end
    rdy_in = 1'b1;
    wait_hit(18'h00400, -1);
    for (int i = 0; i < 4; i++) fetch(18'h00400 + 18'(4 * i), 0);

    // async reset between edges mid-fill
    @(negedge clk_in);
    push_line(18'h00500);
    if_req_in = 1'b1; if_addr_in = 18'h00500;
    wait_addr(18'h00504);
    #1 rst_n_in = 1'b0;
    #1;
    check("arst_req", 32'(mc_req_out), 32'd0);
    check("arst_addr", 32'(mc_addr_out), 32'd0);
    if_req_in = 1'b0;
    exp_q.delete();
    @(negedge clk_in) rst_n_in = 1'b1;
    probe(18'h00100, 1'b0);
    probe(18'h00400, 1'b0);
    probe(18'h20000, 1'b0);

    @(negedge clk_in);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
